iiitb_apb_mem_slave: RTL and testbench
======================================

Name: iiitb_apb_mem_slave

Overview:
- APB2 completer stage directly downstream of the APB master. Consumes the master's PSEL/PENABLE/PWRITE/PADDR/PWDATA bus and returns PREADY/PRDATA/PSLVERR.
- Holds a byte-wide register-file memory and inserts a configurable number of wait states per transfer.
- Two instances (slave 1 and slave 2) are decoded by the master from address bit 8. This block sees only the low 8 address bits.

Parameters:
- DEPTH, 64, number of byte locations; valid addresses are 0..DEPTH-1.
- ADDR_W, 8, PADDR width.
- DATA_W, 8, PWDATA/PRDATA width.

Ports:
- PCLK  in  1  bus clock; all state changes on its rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  slave select from master.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  DATA_W  write data.
- cfg_wait  in  4  wait states to insert; sampled in the setup cycle.
- PREADY  out  1  transfer completes in a cycle with PSEL & PENABLE & PREADY.
- PRDATA  out  DATA_W  read data; valid only when PREADY=1 on a read.
- PSLVERR  out  1  error flag; valid only when PREADY=1.

Behaviour:
- One clock (PCLK). Reset is synchronous, active-high (PRESET) and takes priority over everything.
  - On reset: state=IDLE, wait counter=0, captured addr/data/dir=0, PREADY=0, PRDATA=0, PSLVERR=0.
  - Memory contents are not cleared by reset.
- FSM states: IDLE, ACCESS.
- IDLE:
  - PREADY=0.
  - On PSEL=1 & PENABLE=0 (setup cycle): capture PADDR, PWDATA, PWRITE; load counter with cfg_wait; next state = ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - PREADY = (counter==0), combinational from state and counter.
  - If PSEL=0: protocol abort. Next state = IDLE, no memory write, counter cleared.
  - Else if counter!=0: decrement the counter and stay in ACCESS.
  - Else (the completion cycle): next state = IDLE. On a write with a valid address, mem[addr] <= captured PWDATA at this edge.
- Latency: cfg_wait=N gives PREADY high on the (N+1)th ACCESS cycle. Total transfer length is N+2 cycles including setup.
- Back-to-back transfers: a new setup cycle may immediately follow the completion cycle. No idle cycle is required.
- PRDATA:
  - Driven combinationally from mem[captured addr] while in ACCESS with a valid read.
  - 0 in every other case, including writes, errors and IDLE.
- PSLVERR:
  - Asserted together with PREADY when captured addr >= DEPTH. The write is suppressed and PRDATA=0.
  - 0 at all other times.
- Captured values are frozen during ACCESS. Changes on PADDR/PWDATA/PWRITE during wait states are ignored.
- PENABLE=1 while in IDLE (no setup seen): ignored, stay in IDLE.
- Read after write to the same address in the next transfer returns the new data.

Optional Feature:
- Macro: IIITB_APB_SLV_ERRCNT_EN.
- When defined:
  - Adds output err_cnt[7:0]. It increments on each completion cycle with PSLVERR=1 and on each PSEL abort in ACCESS.
  - Saturates at 255 and is cleared by PRESET.
- When not defined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Package iiitb_apb_pkg:
  - state encoding constants ST_IDLE=1'b0, ST_ACCESS=1'b1;
  - default DATA_W/ADDR_W;
  - WAIT_W=4.
- One sub-module: iiitb_apb_wait_ctr.
  - Inputs: load (value), enable-decrement, clear.
  - Output: zero flag.
  - Used by the FSM to generate PREADY.
- Memory array and FSM stay in the top module.

Test Plan:
- Reset, then cfg_wait=0. Write addr 3 data 8'h06, then read addr 3: PREADY high on the first ACCESS cycle each time; PRDATA=8'h06; PSLVERR=0.
- cfg_wait=3. Write addr 5 data 8'hA5: PREADY low for 3 ACCESS cycles, high on the 4th. Memory is unchanged until that edge. A subsequent read returns 8'hA5.
- Write addr 8'd70 (>= DEPTH 64) data 8'h09: PSLVERR=1 with PREADY. A read of addr 70 returns PRDATA=0 and PSLVERR=1. No valid location is modified.
- Abort: cfg_wait=4, write addr 2 data 8'hFF, drop PSEL after 2 wait cycles. The FSM returns to IDLE and a read of addr 2 returns the old value. With IIITB_APB_SLV_ERRCNT_EN defined, err_cnt increments by 1.
- Back-to-back: write addresses 0..7 with data 2*i, then read addresses 0..7, with no idle cycles between transfers. All reads match. Also change PADDR mid-wait on one transfer: the captured address is used.
- Assert PRESET during ACCESS with a pending write: the next cycle shows IDLE, PREADY=0 and PSLVERR=0, and the pending write is not committed.

Source files
------------

// File: rtl/iiitb_apb_mem_slave_pkg.sv
// Shared constants for the APB memory completer.
// FSM state encoding, default bus widths and wait-counter width.
package iiitb_apb_pkg;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACCESS = 1'b1;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;
   localparam int WAIT_W     = 4;

endpackage

// File: rtl/iiitb_apb_mem_slave_if.sv
// APB2 bus between the master and one memory completer.
// The master drives the request; the slave returns ready/data/error.
interface iiitb_apb_mem_slave_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);

   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic              PREADY;
   logic [DATA_W-1:0] PRDATA;
   logic              PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PREADY, PRDATA, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PREADY, PRDATA, PSLVERR
   );

endinterface

// File: rtl/iiitb_apb_mem_slave_wait_ctr.sv
// Wait-state down-counter for the APB memory completer.
// Loaded at setup, decremented per wait cycle; zero flag drives PREADY.
module iiitb_apb_wait_ctr
   import iiitb_apb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WAIT_W-1:0] load_val,
   input  logic              dec,
   input  logic              clr,
   output logic              zero
);

   logic [WAIT_W-1:0] cnt;

   // Reset/load/clear/decrement, in that priority order.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (clr)
         cnt <= '0;
      else if (dec && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/iiitb_apb_mem_slave.sv
// APB2 byte-memory completer with programmable wait states.
// Optional error counter output enabled by IIITB_APB_SLV_ERRCNT_EN.
module iiitb_apb_mem_slave
   import iiitb_apb_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic [WAIT_W-1:0] cfg_wait,
   iiitb_apb_mem_slave_if.slave bus
`ifdef IIITB_APB_SLV_ERRCNT_EN
   ,
   output logic [7:0]        err_cnt
`endif
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   logic [0:0]        state;
   logic [ADDR_W-1:0] cap_addr;
   logic [DATA_W-1:0] cap_data;
   logic              cap_wr;
   logic [DATA_W-1:0] mem [DEPTH];

   logic acc;
   logic setup;
   logic abort;
   logic ctr_zero;
   logic done;
   logic addr_ok;

   assign acc     = (state == ST_ACCESS);
   assign setup   = !acc && bus.PSEL && !bus.PENABLE;
   assign abort   = acc && !bus.PSEL;
   assign done    = acc && bus.PSEL && ctr_zero;
   assign addr_ok = ({1'b0, cap_addr} < DEPTH_L);

   iiitb_apb_wait_ctr u_wait_ctr (
      .clk      (PCLK),
      .rst      (PRESET),
      .load     (setup),
      .load_val (cfg_wait),
      .dec      (acc && bus.PSEL && !ctr_zero),
      .clr      (abort),
      .zero     (ctr_zero)
   );

   // FSM and request capture; captured fields stay frozen in ACCESS.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state    <= ST_IDLE;
         cap_addr <= '0;
         cap_data <= '0;
         cap_wr   <= 1'b0;
      end else if (setup) begin
         state    <= ST_ACCESS;
         cap_addr <= bus.PADDR;
         cap_data <= bus.PWDATA;
         cap_wr   <= bus.PWRITE;
      end else if (abort || done) begin
         state    <= ST_IDLE;
      end
   end

   // Commit a write only on the completion edge to a valid location.
   always_ff @(posedge PCLK) begin
      if (!PRESET && done && cap_wr && addr_ok)
         mem[cap_addr[IDX_W-1:0]] <= cap_data;
   end

   assign bus.PREADY  = acc && ctr_zero;
   assign bus.PSLVERR = acc && ctr_zero && !addr_ok;
   assign bus.PRDATA  = (acc && !cap_wr && addr_ok) ?
                        mem[cap_addr[IDX_W-1:0]] : '0;

`ifdef IIITB_APB_SLV_ERRCNT_EN
   // Count error completions and aborts, saturating at 255.
   always_ff @(posedge PCLK) begin
      if (PRESET)
         err_cnt <= '0;
      else if (((done && !addr_ok) || abort) && err_cnt != 8'hFF)
         err_cnt <= err_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_iiitb_apb_mem_slave.sv
// Self-checking bench for iiitb_apb_mem_slave.
// Directed plan plus randomized back-to-back transfers vs. a memory model.
module tb_iiitb_apb_mem_slave;
   import iiitb_apb_pkg::*;

   localparam int DEPTH = 64;

   logic       PCLK = 1'b0;
   logic       PRESET;
   logic [3:0] cfg_wait;
`ifdef IIITB_APB_SLV_ERRCNT_EN
   logic [7:0] err_cnt;
`endif

   iiitb_apb_mem_slave_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   iiitb_apb_mem_slave #(.DEPTH(DEPTH)) dut (
      .PCLK     (PCLK),
      .PRESET   (PRESET),
      .cfg_wait (cfg_wait),
      .bus      (bus)
`ifdef IIITB_APB_SLV_ERRCNT_EN
      ,
      .err_cnt  (err_cnt)
`endif
   );

   always #5 PCLK = ~PCLK;

   int         n_chk = 0;
   int         n_err = 0;
   logic [7:0] mdl_mem [DEPTH];
   int         mdl_errs = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle_cyc();
      @(negedge PCLK);
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
   endtask

   // One complete transfer; setup is driven on the next negedge.
   task automatic xfer(input bit wr, input int addr, input logic [7:0] data,
                       input int nw, input bit glitch);
      bit         bad;
      logic [7:0] exp_rd;
      bad    = (addr >= DEPTH);
      exp_rd = (!wr && !bad) ? mdl_mem[addr] : 8'h00;
      @(negedge PCLK);
      bus.PSEL    = 1'b1;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = wr;
      bus.PADDR   = 8'(addr);
      bus.PWDATA  = data;
      cfg_wait    = 4'(nw);
      for (int k = 0; k <= nw; k++) begin
         @(negedge PCLK);
         bus.PENABLE = 1'b1;
         if (glitch && k == 0) begin
            bus.PADDR  = bus.PADDR ^ 8'h15;
            bus.PWDATA = ~data;
            bus.PWRITE = ~wr;
            cfg_wait   = 4'hF;
         end
         check("pready", 32'(bus.PREADY), 32'(k == nw));
         if (k == nw) begin
            check("pslverr", 32'(bus.PSLVERR), 32'(bad));
            check("prdata", 32'(bus.PRDATA), 32'(exp_rd));
         end else begin
            check("pslverr_wait", 32'(bus.PSLVERR), 32'd0);
         end
      end
      if (wr && !bad)
         mdl_mem[addr] = data;
      if (bad && mdl_errs < 255)
         mdl_errs++;
   endtask

   initial begin
      logic [7:0] d;
      PRESET      = 1'b1;
      cfg_wait    = 4'd0;
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = 1'b0;
      bus.PADDR   = '0;
      bus.PWDATA  = '0;
      repeat (2) @(negedge PCLK);
      check("rst_pready", 32'(bus.PREADY), 32'd0);
      check("rst_pslverr", 32'(bus.PSLVERR), 32'd0);
      check("rst_prdata", 32'(bus.PRDATA), 32'd0);
`ifdef IIITB_APB_SLV_ERRCNT_EN
      check("rst_errcnt", 32'(err_cnt), 32'd0);
`endif
      PRESET = 1'b0;

      for (int i = 0; i < DEPTH; i++)
         xfer(1'b1, i, 8'($urandom), 0, 1'b0);

      xfer(1'b1, 3, 8'h06, 0, 1'b0);
      xfer(1'b0, 3, 8'h00, 0, 1'b0);
      check("rd3_model", 32'(mdl_mem[3]), 32'h06);

      xfer(1'b1, 5, 8'hA5, 3, 1'b0);
      xfer(1'b0, 5, 8'h00, 3, 1'b0);

      xfer(1'b1, 70, 8'h09, 0, 1'b0);
      xfer(1'b0, 70, 8'h00, 0, 1'b0);
      xfer(1'b0, 6, 8'h00, 0, 1'b0);

      // Abort: drop PSEL after two wait cycles.
      d = ~mdl_mem[2];
      @(negedge PCLK);
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
      bus.PWRITE = 1'b1; bus.PADDR = 8'd2; bus.PWDATA = d;
      cfg_wait = 4'd4;
      @(negedge PCLK);
      bus.PENABLE = 1'b1;
      check("abort_w1", 32'(bus.PREADY), 32'd0);
      @(negedge PCLK);
      check("abort_w2", 32'(bus.PREADY), 32'd0);
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
      @(negedge PCLK);
      check("abort_idle", 32'(bus.PREADY), 32'd0);
      mdl_errs++;
`ifdef IIITB_APB_SLV_ERRCNT_EN
      check("abort_errcnt", 32'(err_cnt), 32'(mdl_errs));
`endif
      xfer(1'b0, 2, 8'h00, 0, 1'b0);

      // PENABLE without setup is ignored in IDLE.
      @(negedge PCLK);
      bus.PSEL = 1'b1; bus.PENABLE = 1'b1;
      @(negedge PCLK);
      check("pen_no_setup", 32'(bus.PREADY), 32'd0);
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;

      for (int i = 0; i < 8; i++)
         xfer(1'b1, i, 8'(2 * i), 1, i == 4);
      for (int i = 0; i < 8; i++)
         xfer(1'b0, i, 8'h00, 0, i == 2);

      // Reset during ACCESS with a pending write.
      d = ~mdl_mem[9];
      @(negedge PCLK);
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
      bus.PWRITE = 1'b1; bus.PADDR = 8'd9; bus.PWDATA = d;
      cfg_wait = 4'd0;
      @(negedge PCLK);
      bus.PENABLE = 1'b1;
      check("prst_ready_pre", 32'(bus.PREADY), 32'd1);
      PRESET = 1'b1;
      @(negedge PCLK);
      check("prst_pready", 32'(bus.PREADY), 32'd0);
      check("prst_pslverr", 32'(bus.PSLVERR), 32'd0);
      check("prst_prdata", 32'(bus.PRDATA), 32'd0);
      PRESET = 1'b0;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
      mdl_errs = 0;
`ifdef IIITB_APB_SLV_ERRCNT_EN
      check("prst_errcnt", 32'(err_cnt), 32'd0);
`endif
      xfer(1'b0, 9, 8'h00, 0, 1'b0);

      for (int t = 0; t < 200; t++) begin
         if ($urandom_range(0, 3) == 0)
            idle_cyc();
         xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 79)),
              8'($urandom), int'($urandom_range(0, 3)),
              $urandom_range(0, 7) == 0);
      end
      idle_cyc();
`ifdef IIITB_APB_SLV_ERRCNT_EN
      check("final_errcnt", 32'(err_cnt), 32'(mdl_errs));
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
